cmd_decoder: RTL and testbench

Parametrised command decoder between the UART receive path and the IAGC control FSM. It takes a byte stream, splits each command byte into opcode and parameter, and validates the opcode against a mask. Opcodes flagged as extended collect one extra argument byte, with a timeout. A decoded command is held under a valid/ack handshake until the IAGC FSM consumes it, and bad opcodes, timeouts and overruns are reported.

---
 rtl/cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_cmd_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_decoder.sv
// cmd_decoder: splits received bytes into opcode/parameter, validates the
// opcode, optionally collects one argument byte (with timeout), and holds
// the decoded command under a valid/ack handshake. Errors are pulsed,
// latched as a code and counted with saturation.
module cmd_decoder #(
  parameter int DATA_SIZE                        = 8,
  parameter int CMD_OP_SIZE                      = 4,
  parameter int CMD_PARAM_SIZE                   = 4,
  parameter logic [2**CMD_OP_SIZE-1:0] OP_VALID_MASK = 16'h01FF,
  parameter logic [2**CMD_OP_SIZE-1:0] OP_EXT_MASK   = 16'h0080,
  parameter int TIMEOUT_CYCLES                   = 1000,
  parameter int ERR_CNT_SIZE                     = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [DATA_SIZE-1:0]      i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_cmd_ack,
  output logic                      o_cmd_valid,
  output logic [CMD_OP_SIZE-1:0]    o_cmd_op,
  output logic [CMD_PARAM_SIZE-1:0] o_cmd_param,
  output logic [DATA_SIZE-1:0]      o_cmd_ext,
  output logic                      o_cmd_error,
  output logic [1:0]                o_error_code,
  output logic [ERR_CNT_SIZE-1:0]   o_error_count,
  output logic                      o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_BAD_OP  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXT_WAIT = 2'd1,
    PRESENT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CMD_OP_SIZE-1:0]    op_q, op_d;
  logic [CMD_PARAM_SIZE-1:0] param_q, param_d;
  logic [DATA_SIZE-1:0]      ext_q, ext_d;
  logic [CNT_W-1:0]          tcnt_q, tcnt_d;
  logic                      err_pulse_q, err_pulse_d;
  logic [1:0]                err_code_q, err_code_d;
  logic [ERR_CNT_SIZE-1:0]   err_cnt_q, err_cnt_d;

  logic                      raise_err;
  logic [1:0]                raise_code;
  logic [CMD_OP_SIZE-1:0]    rx_op;
  logic [CMD_PARAM_SIZE-1:0] rx_param;

  assign rx_op    = i_rx_data[DATA_SIZE-1 -: CMD_OP_SIZE];
  assign rx_param = i_rx_data[CMD_PARAM_SIZE-1:0];

  // Next-state, command latching and error detection
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    param_d    = param_q;
    ext_d      = ext_q;
    tcnt_d     = tcnt_q;
    raise_err  = 1'b0;
    raise_code = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (!OP_VALID_MASK[rx_op]) begin
            raise_err  = 1'b1;
            raise_code = ERR_BAD_OP;
          end else begin
            op_d    = rx_op;
            param_d = rx_param;
            if (OP_EXT_MASK[rx_op]) begin
              tcnt_d  = '0;
              state_d = EXT_WAIT;
            end else begin
              ext_d   = '0;
              state_d = PRESENT;
            end
          end
        end
      end
      EXT_WAIT: begin
        // A byte on the final counted cycle still wins over the timeout.
        if (i_rx_valid) begin
          ext_d   = i_rx_data;
          state_d = PRESENT;
        end else if (tcnt_q == CNT_LAST) begin
          raise_err  = 1'b1;
          raise_code = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      PRESENT: begin
        if (i_rx_valid) begin
          raise_err  = 1'b1;
          raise_code = ERR_OVERRUN;
        end
        if (i_cmd_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_pulse_d = raise_err;
    err_code_d  = raise_code;
    err_cnt_d   = err_cnt_q;
    if (raise_err && (err_cnt_q != {ERR_CNT_SIZE{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_SIZE'(1);
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      param_q     <= '0;
      ext_q       <= '0;
      tcnt_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      param_q     <= param_d;
      ext_q       <= ext_d;
      tcnt_q      <= tcnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_cmd_valid   = (state_q == PRESENT);
  assign o_busy        = (state_q != IDLE);
  assign o_cmd_op      = op_q;
  assign o_cmd_param   = param_q;
  assign o_cmd_ext     = ext_q;
  assign o_cmd_error   = err_pulse_q;
  assign o_error_code  = err_code_q;
  assign o_error_count = err_cnt_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder with TIMEOUT_CYCLES=10.
module tb_cmd_decoder;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_valid = 1'b0;
  logic       i_cmd_ack = 1'b0;
  logic       o_cmd_valid;
  logic [3:0] o_cmd_op;
  logic [3:0] o_cmd_param;
  logic [7:0] o_cmd_ext;
  logic       o_cmd_error;
  logic [1:0] o_error_code;
  logic [7:0] o_error_count;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  cmd_decoder #(
    .DATA_SIZE(8), .CMD_OP_SIZE(4), .CMD_PARAM_SIZE(4),
    .OP_VALID_MASK(16'h01FF), .OP_EXT_MASK(16'h0080),
    .TIMEOUT_CYCLES(10), .ERR_CNT_SIZE(8)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_cmd_ack(i_cmd_ack),
    .o_cmd_valid(o_cmd_valid), .o_cmd_op(o_cmd_op), .o_cmd_param(o_cmd_param),
    .o_cmd_ext(o_cmd_ext), .o_cmd_error(o_cmd_error),
    .o_error_code(o_error_code), .o_error_count(o_error_count), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Present one byte for exactly one capturing edge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic ack_cmd();
    i_cmd_ack = 1'b1;
    tick();
    i_cmd_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_valid", o_cmd_valid, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_error", o_cmd_error, 0);
    check_val("rst_code", o_error_code, 0);
    check_val("rst_count", o_error_count, 0);
    check_val("rst_op", o_cmd_op, 0);
    tick();
    i_reset = 1'b0;
    tick();

    // Plain command 0x23
    send_byte(8'h23);
    check_val("c23_valid", o_cmd_valid, 1);
    check_val("c23_op", o_cmd_op, 2);
    check_val("c23_param", o_cmd_param, 3);
    check_val("c23_ext", o_cmd_ext, 0);
    check_val("c23_busy", o_busy, 1);
    tick();
    check_val("c23_hold_valid", o_cmd_valid, 1);
    check_val("c23_hold_op", o_cmd_op, 2);
    ack_cmd();
    check_val("c23_ack_valid", o_cmd_valid, 0);
    check_val("c23_ack_busy", o_busy, 0);

    // Illegal opcode 0xA5
    send_byte(8'hA5);
    check_val("bad_error", o_cmd_error, 1);
    check_val("bad_code", o_error_code, 1);
    check_val("bad_count", o_error_count, 1);
    check_val("bad_valid", o_cmd_valid, 0);
    tick();
    check_val("bad_pulse_end", o_cmd_error, 0);
    check_val("bad_code_hold", o_error_code, 1);

    // Extended command 0x71, argument 0xC4 three edges later
    send_byte(8'h71);
    check_val("ext_busy", o_busy, 1);
    check_val("ext_wait_valid", o_cmd_valid, 0);
    tick();
    tick();
    send_byte(8'hC4);
    check_val("ext_valid", o_cmd_valid, 1);
    check_val("ext_op", o_cmd_op, 7);
    check_val("ext_param", o_cmd_param, 1);
    check_val("ext_arg", o_cmd_ext, 8'hC4);
    check_val("ext_no_err", o_cmd_error, 0);
    check_val("ext_count", o_error_count, 1);
    ack_cmd();

    // Timeout: first byte at edge N, error after edge N+10
    send_byte(8'h71);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_val($sformatf("to_wait%0d_err", k), o_cmd_error, 0);
      check_val($sformatf("to_wait%0d_busy", k), o_busy, 1);
    end
    tick();
    check_val("to_error", o_cmd_error, 1);
    check_val("to_code", o_error_code, 2);
    check_val("to_count", o_error_count, 2);
    check_val("to_busy", o_busy, 0);
    check_val("to_valid", o_cmd_valid, 0);
    tick();

    // Argument on the last counted cycle is still accepted
    send_byte(8'h71);
    for (int k = 1; k <= 9; k++) tick();
    send_byte(8'h5A);
    check_val("edge_valid", o_cmd_valid, 1);
    check_val("edge_no_err", o_cmd_error, 0);
    check_val("edge_arg", o_cmd_ext, 8'h5A);
    check_val("edge_count", o_error_count, 2);
    ack_cmd();

    // Overrun with same-cycle ack
    send_byte(8'h12);
    check_val("ov_valid", o_cmd_valid, 1);
    check_val("ov_op", o_cmd_op, 1);
    check_val("ov_param", o_cmd_param, 2);
    i_rx_data  = 8'h34;
    i_rx_valid = 1'b1;
    i_cmd_ack  = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_cmd_ack  = 1'b0;
    check_val("ov_error", o_cmd_error, 1);
    check_val("ov_code", o_error_code, 3);
    check_val("ov_count", o_error_count, 3);
    check_val("ov_consumed", o_cmd_valid, 0);
    tick();
    check_val("ov_not_presented", o_cmd_valid, 0);
    check_val("ov_idle", o_busy, 0);

    // Overrun without ack keeps the held command
    send_byte(8'h45);
    send_byte(8'h67);
    check_val("ov2_error", o_cmd_error, 1);
    check_val("ov2_valid", o_cmd_valid, 1);
    check_val("ov2_op", o_cmd_op, 4);
    check_val("ov2_param", o_cmd_param, 5);
    check_val("ov2_count", o_error_count, 4);
    ack_cmd();

    // 300 back-to-back illegal bytes saturate the counter
    i_rx_data  = 8'hA5;
    i_rx_valid = 1'b1;
    repeat (251) tick();
    check_val("sat_reach", o_error_count, 255);
    repeat (49) tick();
    check_val("sat_hold", o_error_count, 255);
    check_val("sat_error", o_cmd_error, 1);

    // Asynchronous reset mid-stream
    #2;
    i_reset = 1'b1;
    #1;
    check_val("arst_count", o_error_count, 0);
    check_val("arst_code", o_error_code, 0);
    check_val("arst_error", o_cmd_error, 0);
    check_val("arst_busy", o_busy, 0);
    i_rx_valid = 1'b0;
    tick();
    i_reset = 1'b0;
    tick();
    check_val("post_rst_count", o_error_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
